// File: rtl/vc_output_arbiter.sv
// Output-port arbiter: packet-level round-robin over VC buffers, wormhole lock, registered flit out.
// Optional VC_ARB_PKT_COUNT_EN adds a saturating completed-packet counter with clear.
module vc_output_arbiter #(
   parameter int NUM_VC = 4,
   parameter int ID_W   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [32*NUM_VC-1:0]   vc_flit,
   input  logic [NUM_VC-1:0]      vc_valid,
   input  logic [NUM_VC-1:0]      vc_req,
   input  logic                   out_ready,
   output logic [NUM_VC-1:0]      vc_stop,
   output logic [31:0]            flit_out,
   output logic                   flit_valid,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy
`ifdef VC_ARB_PKT_COUNT_EN
   ,
   output logic [15:0]            pkt_count,
   input  logic                   pkt_count_clr
`endif
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [31:0]       flit_q, flit_d;
   logic              valid_q, valid_d;

   logic [31:0]       flit_arr [NUM_VC];
   logic [NUM_VC-1:0] cand;

   // Only header-bearing flits (type 10 or 11, i.e. bit 31 set) may open a grant.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         assign flit_arr[gi] = vc_flit[32*gi +: 32];
         assign cand[gi]     = vc_valid[gi] & vc_req[gi] & vc_flit[32*gi+31];
      end
   endgenerate

   function automatic logic [ID_W-1:0] next_vc(input logic [ID_W-1:0] x);
      return (int'(x) == NUM_VC-1) ? '0 : x + 1'b1;
   endfunction

   logic            win_found;
   logic [ID_W-1:0] win_idx;
   int              idx;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int i = 0; i < NUM_VC; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_VC;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   logic [31:0] win_flit, lock_flit;
   logic        xfer_idle, xfer_lock;

   assign win_flit  = flit_arr[win_idx];
   assign lock_flit = flit_arr[grant_q];
   assign xfer_idle = (state_q == ST_IDLE) & win_found & out_ready;
   assign xfer_lock = (state_q == ST_LOCKED) & out_ready & vc_valid[grant_q];

   // Hold every VC while reset is asserted so no buffer advances into a dropped packet.
   always_comb begin
      vc_stop = '1;
      if (!reset) begin
         if (state_q == ST_LOCKED)
            vc_stop[grant_q] = ~(out_ready & vc_valid[grant_q]);
         else if (xfer_idle)
            vc_stop[win_idx] = 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      flit_d   = flit_q;
      valid_d  = 1'b0;
      if (xfer_idle) begin
         flit_d  = win_flit;
         valid_d = 1'b1;
         grant_d = win_idx;
         if (win_flit[31:30] == 2'b10)
            state_d = ST_LOCKED;
         else
            rr_ptr_d = next_vc(win_idx);
      end else if (xfer_lock) begin
         flit_d  = lock_flit;
         valid_d = 1'b1;
         if (lock_flit[31:30] == 2'b01) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_vc(grant_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         flit_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         flit_q   <= flit_d;
         valid_q  <= valid_d;
      end
   end

   assign flit_out   = flit_q;
   assign flit_valid = valid_q;
   assign grant_id   = grant_q;
   assign busy       = (state_q == ST_LOCKED);

`ifdef VC_ARB_PKT_COUNT_EN
   // Types 01 and 11 both carry bit 30, so that bit marks a packet end.
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic        pkt_end;

   assign pkt_end = (xfer_idle & win_flit[30]) | (xfer_lock & lock_flit[30]);

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (pkt_count_clr)
         pkt_cnt_d = '0;
      else if (pkt_end && pkt_cnt_q != 16'hFFFF)
         pkt_cnt_d = pkt_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pkt_cnt_q <= '0;
      else
         pkt_cnt_q <= pkt_cnt_d;
   end

   assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_vc_output_arbiter.sv
// Directed table-driven bench for vc_output_arbiter (NUM_VC = 4) plus hand-written corner sequences.
module tb_vc_output_arbiter;

   logic         clk;
   logic         reset;
   logic [127:0] vc_flit;
   logic [3:0]   vc_valid;
   logic [3:0]   vc_req;
   logic         out_ready;
   logic [3:0]   vc_stop;
   logic [31:0]  flit_out;
   logic         flit_valid;
   logic [1:0]   grant_id;
   logic         busy;
`ifdef VC_ARB_PKT_COUNT_EN
   logic [15:0]  pkt_count;
   logic         pkt_count_clr;
`endif

   vc_output_arbiter #(.NUM_VC(4), .ID_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .vc_flit    (vc_flit),
      .vc_valid   (vc_valid),
      .vc_req     (vc_req),
      .out_ready  (out_ready),
      .vc_stop    (vc_stop),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .grant_id   (grant_id),
      .busy       (busy)
`ifdef VC_ARB_PKT_COUNT_EN
      ,
      .pkt_count     (pkt_count),
      .pkt_count_clr (pkt_count_clr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [3:0]   valid;
      logic [3:0]   req;
      logic [127:0] flits;
      logic         ordy;
      logic [3:0]   e_stop;
      logic         e_fv;
      logic [31:0]  e_fo;
      logic [1:0]   e_gid;
      logic         e_busy;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [127:0] f4(input logic [31:0] v3, v2, v1, v0);
      return {v3, v2, v1, v0};
   endfunction

   task automatic add(input logic rst, input logic [3:0] valid, req, input logic [127:0] flits,
                      input logic ordy, input logic [3:0] e_stop, input logic e_fv,
                      input logic [31:0] e_fo, input logic [1:0] e_gid, input logic e_busy);
      vec_t v;
      v.rst = rst; v.valid = valid; v.req = req; v.flits = flits; v.ordy = ordy;
      v.e_stop = e_stop; v.e_fv = e_fv; v.e_fo = e_fo; v.e_gid = e_gid; v.e_busy = e_busy;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] valid, req, input logic [127:0] flits, input logic ordy);
      vc_valid  = valid;
      vc_req    = req;
      vc_flit   = flits;
      out_ready = ordy;
   endtask

   logic [127:0] rr_f;
   logic         got;

   initial begin
      rr_f = f4(32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000);
      // reset
      add(1, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'h0, 0, 0);
      add(1, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'h0, 0, 0);
      // VC2 three-flit packet, then rr_ptr = 3 probe
      add(0, 4'h4, 4'h4, f4(0, 32'h8000_0001, 0, 0), 1, 4'hB, 1, 32'h8000_0001, 2, 1);
      add(0, 4'h4, 4'h4, f4(0, 32'h0000_0002, 0, 0), 1, 4'hB, 1, 32'h0000_0002, 2, 1);
      add(0, 4'h4, 4'h4, f4(0, 32'h4000_0003, 0, 0), 1, 4'hB, 1, 32'h4000_0003, 2, 0);
      add(0, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'h4000_0003, 2, 0);
      add(0, 4'h9, 4'h9, f4(32'hC000_00A3, 0, 0, 32'hC000_00A0), 1, 4'h7, 1, 32'hC000_00A3, 3, 0);
      add(0, 4'h1, 4'h1, f4(0, 0, 0, 32'hC000_00A0), 1, 4'hE, 1, 32'hC000_00A0, 0, 0);
      add(0, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'hC000_00A0, 0, 0);
      // round-robin over single-flit packets from reset
      add(1, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'h0, 0, 0);
      add(0, 4'hF, 4'hF, rr_f, 1, 4'hE, 1, 32'hC000_0000, 0, 0);
      add(0, 4'hE, 4'hF, rr_f, 1, 4'hD, 1, 32'hC000_0001, 1, 0);
      add(0, 4'hC, 4'hF, rr_f, 1, 4'hB, 1, 32'hC000_0002, 2, 0);
      add(0, 4'hF, 4'hF, rr_f, 1, 4'h7, 1, 32'hC000_0003, 3, 0);
      add(0, 4'h7, 4'hF, rr_f, 1, 4'hE, 1, 32'hC000_0000, 0, 0);
      add(0, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'hC000_0000, 0, 0);
      // backpressure mid-packet on VC1
      add(0, 4'h2, 4'h2, f4(0, 0, 32'h8000_0011, 0), 1, 4'hD, 1, 32'h8000_0011, 1, 1);
      add(0, 4'h2, 4'h2, f4(0, 0, 32'h0000_0012, 0), 1, 4'hD, 1, 32'h0000_0012, 1, 1);
      for (int k = 0; k < 3; k++)
         add(0, 4'h2, 4'h2, f4(0, 0, 32'h0000_0013, 0), 0, 4'hF, 0, 32'h0000_0012, 1, 1);
      add(0, 4'h2, 4'h2, f4(0, 0, 32'h0000_0013, 0), 1, 4'hD, 1, 32'h0000_0013, 1, 1);
      add(0, 4'h2, 4'h2, f4(0, 0, 32'h4000_0014, 0), 1, 4'hD, 1, 32'h4000_0014, 1, 0);
      add(0, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'h4000_0014, 1, 0);
      // bubble on locked VC3 with VC0 waiting, then wrap to VC0
      add(0, 4'h9, 4'h9, f4(32'h8000_0031, 0, 0, 32'hC000_00F0), 1, 4'h7, 1, 32'h8000_0031, 3, 1);
      add(0, 4'h9, 4'h9, f4(32'h0000_0032, 0, 0, 32'hC000_00F0), 1, 4'h7, 1, 32'h0000_0032, 3, 1);
      for (int k = 0; k < 2; k++)
         add(0, 4'h1, 4'h9, f4(32'h0000_0033, 0, 0, 32'hC000_00F0), 1, 4'hF, 0, 32'h0000_0032, 3, 1);
      add(0, 4'h9, 4'h9, f4(32'h4000_0033, 0, 0, 32'hC000_00F0), 1, 4'h7, 1, 32'h4000_0033, 3, 0);
      add(0, 4'h1, 4'h1, f4(0, 0, 0, 32'hC000_00F0), 1, 4'hE, 1, 32'hC000_00F0, 0, 0);
      // IDLE with candidate but no out_ready, then granted
      add(0, 4'h2, 4'h2, f4(0, 0, 32'hC000_0051, 0), 0, 4'hF, 0, 32'hC000_00F0, 0, 0);
      add(0, 4'h2, 4'h2, f4(0, 0, 32'hC000_0051, 0), 1, 4'hD, 1, 32'hC000_0051, 1, 0);
      // candidate filtering: body flit and unrequested VCs ignored
      add(0, 4'hF, 4'h5, f4(32'hC000_0063, 32'h8000_0062, 32'hC000_0061, 32'h0000_0060), 1,
          4'hB, 1, 32'h8000_0062, 2, 1);
      // reset mid-packet, then rr_ptr back at 0
      add(1, 4'h4, 4'h4, f4(0, 32'h0000_0063, 0, 0), 1, 4'hF, 0, 32'h0, 0, 0);
      add(0, 4'h6, 4'h6, f4(0, 32'hC000_0072, 32'hC000_0071, 0), 1, 4'hD, 1, 32'hC000_0071, 1, 0);
      add(0, 4'h0, 4'h0, '0, 1, 4'hF, 0, 32'hC000_0071, 1, 0);

`ifdef VC_ARB_PKT_COUNT_EN
      pkt_count_clr = 1'b0;
`endif
      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         drive(vecs[i].valid, vecs[i].req, vecs[i].flits, vecs[i].ordy);
         #1;
         chk($sformatf("v%0d_stop", i), 32'(vc_stop), 32'(vecs[i].e_stop));
         @(posedge clk); #1;
         chk($sformatf("v%0d_fvalid", i), 32'(flit_valid), 32'(vecs[i].e_fv));
         chk($sformatf("v%0d_fout", i), flit_out, vecs[i].e_fo);
         chk($sformatf("v%0d_grant", i), 32'(grant_id), 32'(vecs[i].e_gid));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
         $display("vec %0d: stop=%h fv=%0d fo=%h gid=%0d busy=%0d",
                  i, vc_stop, flit_valid, flit_out, grant_id, busy);
      end

      // header on the locked VC is forwarded and the lock is kept
      drive(4'h1, 4'h1, f4(0, 0, 0, 32'h8000_0081), 1);
      @(posedge clk); #1;
      chk("perr_hdr_fo", flit_out, 32'h8000_0081);
      chk("perr_hdr_gid", 32'(grant_id), 32'd0);
      drive(4'h1, 4'h1, f4(0, 0, 0, 32'h8000_0082), 1);
      @(posedge clk); #1;
      chk("perr_2nd_fo", flit_out, 32'h8000_0082);
      chk("perr_2nd_busy", 32'(busy), 32'd1);
      drive(4'h1, 4'h1, f4(0, 0, 0, 32'h4000_0083), 1);
      @(posedge clk); #1;
      chk("perr_tail_fo", flit_out, 32'h4000_0083);
      chk("perr_tail_busy", 32'(busy), 32'd0);
      $display("perr seq: fo=%h busy=%0d", flit_out, busy);

      // VC3 waits under out_ready = 0, then a bounded wait for its grant
      drive(4'h8, 4'h8, f4(32'hC000_0091, 0, 0, 0), 0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("hold_fvalid", 32'(flit_valid), 32'd0);
      end
      out_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(posedge clk); #1;
         if (flit_valid) got = 1'b1;
      end
      drive(4'h0, 4'h0, '0, 1);
      chk("wait_grant", 32'(got), 32'd1);
      chk("wait_fo", flit_out, 32'hC000_0091);
      chk("wait_gid", 32'(grant_id), 32'd3);
      $display("wait seq: got=%0d fo=%h gid=%0d", got, flit_out, grant_id);

`ifdef VC_ARB_PKT_COUNT_EN
      chk("pkt_count", 32'(pkt_count), 32'd3);
      pkt_count_clr = 1'b1;
      @(posedge clk); #1;
      pkt_count_clr = 1'b0;
      chk("pkt_count_clr", 32'(pkt_count), 32'd0);
      $display("pkt_count seq: count=%0d", pkt_count);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
